// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, fetch entry layout.
package proc_pkg;

   localparam int                    PROC_WIDTH    = 32;
   localparam logic [PROC_WIDTH-1:0] PROC_RESET_PC = 32'h0000_0000;
   localparam logic [PROC_WIDTH-1:0] PC_INC        = 32'd4;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [PROC_WIDTH-1:0] instr;
      logic [PROC_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_buffer_chk.sv
// Protocol and credit invariants of the fetch prefetch buffer.
module fetch_prefetch_buffer_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clock,
   input logic          reset,
   input logic          rsp_valid,
   input logic          push,
   input logic          full,
   input logic [CW-1:0] inflight,
   input logic [CW-1:0] discard,
   input logic [CW-1:0] fifo_count
);

   a_no_orphan_rsp: assert property (@(posedge clock) disable iff (reset)
      rsp_valid |-> (inflight != {CW{1'b0}}))
      else $error("response arrived with no request in flight");

   a_credit: assert property (@(posedge clock) disable iff (reset)
      ({1'b0, fifo_count} + {1'b0, inflight}) <= (CW+1)'(DEPTH))
      else $error("fifo_count + inflight exceeds DEPTH");

   a_discard_le_inflight: assert property (@(posedge clock) disable iff (reset)
      discard <= inflight)
      else $error("discard exceeds inflight");

   a_no_push_full: assert property (@(posedge clock) disable iff (reset)
      !(push && full))
      else $error("push into full fifo");

endmodule

// File: rtl/sync_fifo.sv
// Small in-order FIFO with flush; storage is not reset, validity comes from count.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output T                       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == {(AW+1){1'b0}});
   assign do_push_s = push & ~full & ~flush;
   assign do_pop_s  = pop & ~empty & ~flush;
   assign head      = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Pointer and occupancy bookkeeping; flush wins over push and pop.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage write port.
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: PC sequencer, request credit tracking, response tagging,
// in-order instruction buffer and redirect flush.
module fetch_prefetch_buffer
   import proc_pkg::*;
#(
   parameter int               WIDTH    = PROC_WIDTH,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = PROC_RESET_PC
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc
);

   localparam int               CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]      CREDITS = (CW+1)'(DEPTH);
   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);

   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [WIDTH-1:0] tag_pc_q, tag_pc_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic [CW-1:0]    discard_q, discard_d;
   logic [CW-1:0]    fifo_count_s;
   logic [CW:0]      used_s;
   logic [WIDTH-1:0] target_s;
   logic             req_fire_s;
   logic             rsp_take_s;
   logic             rsp_keep_s;
   logic             pop_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   fetch_entry_t     push_entry_s;
   fetch_entry_t     head_s;

   // Slots already committed: buffered entries plus requests still out in memory.
   assign used_s         = {1'b0, fifo_count_s} + {1'b0, inflight_q};
   assign imem_req_valid = ~reset & ~redirect_valid & (used_s < CREDITS);
   assign imem_addr      = fetch_pc_q;
   assign req_fire_s     = imem_req_valid & imem_req_ready;

   // A response with nothing in flight is ignored entirely.
   assign rsp_take_s   = imem_rsp_valid & (inflight_q != {CW{1'b0}});
   assign rsp_keep_s   = rsp_take_s & (discard_q == {CW{1'b0}}) & ~redirect_valid;
   assign push_entry_s = '{instr: imem_rsp_data, pc: tag_pc_q};

   assign out_valid = ~reset & ~fifo_empty_s;
   assign out_instr = out_valid ? head_s.instr : {WIDTH{1'b0}};
   assign out_pc    = out_valid ? head_s.pc : {WIDTH{1'b0}};
   assign pop_s     = out_valid & out_ready & ~redirect_valid;

   // Misaligned redirect targets are forced onto a word boundary.
   assign target_s = redirect_pc & {{(WIDTH-2){1'b1}}, 2'b00};

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rsp_keep_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .flush     (redirect_valid),
      .head      (head_s),
      .count     (fifo_count_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Next-state for PC counters and credit/discard counters; redirect dominates.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      tag_pc_d   = tag_pc_q;
      inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_take_s);
      discard_d  = discard_q;
      if (redirect_valid) begin
         fetch_pc_d = target_s;
         tag_pc_d   = target_s;
         discard_d  = inflight_q - CW'(rsp_take_s);
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (rsp_keep_s) begin
            tag_pc_d = tag_pc_q + PC_STEP;
         end else begin
            tag_pc_d = tag_pc_q;
         end
         if (rsp_take_s && (discard_q != {CW{1'b0}})) begin
            discard_d = discard_q - CW'(1);
         end else begin
            discard_d = discard_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         tag_pc_q   <= RESET_PC;
         inflight_q <= {CW{1'b0}};
         discard_q  <= {CW{1'b0}};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_pc_q   <= tag_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   fetch_prefetch_buffer_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clock      (clock),
      .reset      (reset),
      .rsp_valid  (imem_rsp_valid),
      .push       (rsp_keep_s),
      .full       (fifo_full_s),
      .inflight   (inflight_q),
      .discard    (discard_q),
      .fifo_count (fifo_count_s)
   );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with a latency-configurable memory
// model and a scoreboard of expected {instr, pc} deliveries.
module tb_fetch_prefetch_buffer;
   import proc_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t        pend[$];
   fetch_entry_t sb[$];
   fetch_entry_t got_e;
   int           lat      = 1;
   int           cyc      = 0;
   int           acc_cnt  = 0;
   int           exp_disc = 0;
   logic [31:0]  exp_next = 32'h0000_0000;

   fetch_prefetch_buffer #(
      .WIDTH    (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) u_dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clock = ~clock;

   // Instruction memory contents: a hash of the word index.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance into the next cycle; inputs driven afterwards apply to it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Sample the current cycle away from the clock edge.
   task automatic look();
      @(negedge clock);
      #2;
   endtask

   // One reset cycle; returns in the first cycle after release.
   task automatic do_reset(input int new_lat);
      step();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      lat            = new_lat;
      acc_cnt        = 0;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n;
      n = 0;
      look();
      while (!out_valid && n < limit) begin
         step();
         look();
         n++;
      end
      chk1({tag, "_valid"}, out_valid, 1'b1);
   endtask

   // Memory responder: returns accepted requests in order after lat cycles.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
         end
      end
   end

   // Monitor: records accepted requests, checks every delivery against the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            pend.delete();
            sb.delete();
            exp_next = 32'h0000_0000;
         end else if (redirect_valid) begin
            chk1("no_req_in_redirect", imem_req_valid, 1'b0);
            sb.delete();
            exp_next = {redirect_pc[31:2], 2'b00};
         end else begin
            if (out_valid && out_ready) begin
               chk1("delivery_expected", (sb.size() != 0), 1'b1);
               if (sb.size() != 0) begin
                  got_e = sb.pop_front();
                  chk("deliver_pc", out_pc, got_e.pc);
                  chk("deliver_instr", out_instr, got_e.instr);
               end
            end
            if (imem_req_valid && imem_req_ready) begin
               chk("req_addr", imem_addr, exp_next);
               sb.push_back('{instr: mem_word(exp_next), pc: exp_next});
               pend.push_back('{addr: imem_addr, due: cyc + lat});
               exp_next = exp_next + 32'd4;
               acc_cnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      step();
      step();
      look();
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pc", out_pc, 32'h0000_0000);
      chk("rst_out_instr", out_instr, 32'h0000_0000);

      // Streaming with zero-wait 1-cycle memory.
      step();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      reset          = 1'b0;
      look();
      chk1("t1_c1_out_valid", out_valid, 1'b0);
      chk1("t1_c1_req_valid", imem_req_valid, 1'b1);
      chk("t1_c1_addr", imem_addr, 32'h0000_0000);
      step();
      look();
      chk1("t1_c2_out_valid", out_valid, 1'b0);
      step();
      look();
      chk1("t1_c3_out_valid", out_valid, 1'b1);
      chk("t1_c3_pc", out_pc, 32'h0000_0000);
      chk("t1_c3_instr", out_instr, mem_word(32'h0000_0000));
      for (int i = 1; i <= 8; i++) begin
         step();
         look();
         chk1("t1_stream_valid", out_valid, 1'b1);
         chk("t1_stream_pc", out_pc, 32'(i * 4));
      end

      // Backpressure: credits limit acceptance to DEPTH.
      out_ready = 1'b0;
      do_reset(1);
      repeat (20) step();
      look();
      chk("t2_accepts", 32'(acc_cnt), 32'd4);
      chk1("t2_req_stalled", imem_req_valid, 1'b0);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         look();
         chk1("t2_drain_valid", out_valid, 1'b1);
         chk("t2_drain_pc", out_pc, 32'(i * 4));
         step();
      end

      // Redirect with two late responses in flight (3-cycle memory).
      imem_req_ready = 1'b0;
      do_reset(3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0010;
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      step();
      step();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      look();
      exp_disc = pend.size();
      chk("t3_inflight_setup", 32'(exp_disc), 32'd2);
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      look();
      chk("t3_discard", 32'(u_dut.discard_q), 32'(exp_disc));
      wait_valid("t3", 30);
      chk("t3_pc", out_pc, 32'h0000_0100);
      chk("t3_instr", out_instr, mem_word(32'h0000_0100));

      // Misaligned redirect target.
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      look();
      exp_disc = pend.size();
      step();
      redirect_valid = 1'b0;
      look();
      chk("t4_addr", imem_addr, 32'h0000_0100);
      chk("t4_discard", 32'(u_dut.discard_q), 32'(exp_disc));
      wait_valid("t4", 30);
      chk("t4_pc", out_pc, 32'h0000_0100);

      // Redirect coinciding with a response and a ready pop.
      do_reset(1);
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      look();
      chk1("t5_out_valid_pre", out_valid, 1'b1);
      exp_disc = pend.size();
      step();
      redirect_valid = 1'b0;
      look();
      chk1("t5_flushed", out_valid, 1'b0);
      chk("t5_discard", 32'(u_dut.discard_q), 32'(exp_disc));
      wait_valid("t5", 30);
      chk("t5_pc", out_pc, 32'h0000_0200);
      chk("t5_instr", out_instr, mem_word(32'h0000_0200));

      // Reset with three buffered entries and one request in flight.
      out_ready      = 1'b0;
      imem_req_ready = 1'b1;
      do_reset(3);
      step();
      step();
      step();
      imem_req_ready = 1'b0;
      step();
      step();
      step();
      imem_req_ready = 1'b1;
      look();
      chk("t6_fifo_count", 32'(u_dut.fifo_count_s), 32'd3);
      chk("t6_head_pc", out_pc, 32'h0000_0000);
      step();
      imem_req_ready = 1'b0;
      reset          = 1'b1;
      look();
      chk1("t6_rst_out_valid", out_valid, 1'b0);
      chk1("t6_rst_req_valid", imem_req_valid, 1'b0);
      step();
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      look();
      chk1("t6_post_out_valid", out_valid, 1'b0);
      chk("t6_post_out_pc", out_pc, 32'h0000_0000);
      chk("t6_post_out_instr", out_instr, 32'h0000_0000);
      chk1("t6_post_req_valid", imem_req_valid, 1'b1);
      chk("t6_post_addr", imem_addr, 32'h0000_0000);
      wait_valid("t6", 30);
      chk("t6_pc", out_pc, 32'h0000_0000);
      chk("t6_instr", out_instr, mem_word(32'h0000_0000));
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
